spice_node_integrator: RTL and testbench
========================================

Name: spice_node_integrator

Overview:
- Charge-integrating node model for switch-level netlist emulation. It is the receiving end of the current-producing pin, transistor and pullup models.
- Sums up to N signed branch currents each emulation step and integrates them into a registered node voltage, clamped to rail limits.
- Produces a hysteretic digital view of the node and a "settled" flag that the step sequencer uses to detect quiescence.

Parameters:
W, 16, signed width of voltages and currents
N, 4, number of branch-current inputs
SHIFT, 0, arithmetic right shift applied to the summed current (node capacitance)
VHI, 12288, upper rail clamp (signed)
VLO, -12288, lower rail clamp (signed)
VINIT, 0, node voltage after reset
TH_HI, 2048, threshold for digital rise
TH_LO, -2048, threshold for digital fall
SETTLE, 4, consecutive quiet steps before settled asserts (range 1..255)

Ports:
eclk  input  1  emulation clock
ereset_n  input  1  asynchronous, active-low reset
step  input  1  integrate on this edge
force_en  input  1  load force_v into node (external drive or init)
force_v  input  W  signed value for force load
i_in  input  N*W  flattened signed branch currents; slice k = i_in[k*W +: W]
v  output  W  signed node voltage (registered)
p  output  1  hysteretic digital level (registered)
settled  output  1  node quiescent for SETTLE steps
sat_hi  output  1  v equals VHI
sat_lo  output  1  v equals VLO

Behaviour:
- Reset: asynchronous on ereset_n low, regardless of eclk. v=VINIT, p=0, settled=0, quiet counter=0. sat_hi/sat_lo are decoded from v, so they follow VINIT.
- Sum:
  - Sign-extend each current to W+clog2(N)+1 bits and add. Overflow is not permitted.
  - delta = sum >>> SHIFT, arithmetic, truncation toward minus infinity.
- Next value: v_next = clamp(v + delta, VLO, VHI), computed at full width, then truncated to W. No wrap-around is allowed under any input combination.
- Priority per edge: force_en > step > hold.
  - force_en: v <= clamp(force_v, VLO, VHI); quiet counter cleared; settled <= 0.
  - step only: v <= v_next.
  - Neither: all state holds.
- Quiet detection, on step edges:
  - A step is quiet if v_next == v. This includes delta==0 and delta pushing into an already-saturated rail.
  - Quiet step: counter increments, saturating at SETTLE.
  - Non-quiet step: counter is cleared.
  - settled is registered and asserts on the edge where the counter reaches SETTLE.
  - settled deasserts on the edge of any non-quiet step or force.
- Digital FSM, two states LOW and HIGH, evaluated on the value being written to v (same edge as the v update, zero extra latency):
  - LOW -> HIGH when new v > TH_HI.
  - HIGH -> LOW when new v < TH_LO.
  - Otherwise the state holds. p = (state == HIGH).
- sat_hi = (v == VHI) and sat_lo = (v == VLO), combinational from the registered v.
- Reset released mid-operation: the first active edge behaves as from VINIT. A step asserted in the reset-release cycle is honoured if the release meets recovery timing.
- Parameter requirements: VLO < TH_LO <= TH_HI < VHI, VLO <= VINIT <= VHI. The implementation includes elaboration-time checks for these.

Test Plan:
1. Reset, all i_in=0, step=1 held -> v=0, p=0; settled=1 on the 4th step edge; sat_hi=sat_lo=0.
2. i_in[0]=+100, others 0, step held from v=0 -> v increments by 100 per edge; p=1 on the 21st edge (v=2100); settled stays 0.
3. i_in[0..3]=32767 each (sum 131068, needs the wide adder) from v=0 -> v=12288 after one edge, sat_hi=1; settled=1 four quiet steps later. Then i_in[0]=-100, others 0 -> v=12188, settled=0 on the next edge.
4. From v=12288, p=1, i_in[0]=-1000 -> p stays 1 through v=-1712; p=0 on the edge where v reaches -2712. SHIFT=2 variant with i_in[0]=-1 -> delta=-1 each step (floor).
5. Simultaneous force_en=1, force_v=-20000, step=1 -> v=-12288 (force wins, clamped); sat_lo=1, p=0, settled=0, counter cleared.
6. ereset_n pulled low between edges while v=5000, p=1, settled=1 -> outputs immediately v=0, p=0, settled=0. After release, stepping with +100 resumes from 0.

Source files
------------

// File: rtl/spice_node_integrator.sv
// spice_node_integrator: sums signed branch currents into a clamped node voltage,
// with a hysteretic digital view and a quiescence flag for the step sequencer.
module spice_node_integrator #(
    parameter int W      = 16,
    parameter int N      = 4,
    parameter int SHIFT  = 0,
    parameter int VHI    = 12288,
    parameter int VLO    = -12288,
    parameter int VINIT  = 0,
    parameter int TH_HI  = 2048,
    parameter int TH_LO  = -2048,
    parameter int SETTLE = 4
) (
    input  logic           eclk,
    input  logic           ereset_n,
    input  logic           step,
    input  logic           force_en,
    input  logic [W-1:0]   force_v,
    input  logic [N*W-1:0] i_in,
    output logic [W-1:0]   v,
    output logic           p,
    output logic           settled,
    output logic           sat_hi,
    output logic           sat_lo
);
    localparam int SW = W + $clog2(N) + 1;
    localparam int SX = SW + 1;
    localparam logic signed [SX-1:0] HI_X    = SX'(VHI);
    localparam logic signed [SX-1:0] LO_X    = SX'(VLO);
    localparam logic signed [W-1:0]  VHI_W   = W'(VHI);
    localparam logic signed [W-1:0]  VLO_W   = W'(VLO);
    localparam logic signed [W-1:0]  VINIT_W = W'(VINIT);
    localparam logic signed [W-1:0]  TH_HI_W = W'(TH_HI);
    localparam logic signed [W-1:0]  TH_LO_W = W'(TH_LO);
    localparam logic [7:0]           SET8    = 8'(SETTLE);

    if (!(VLO < TH_LO && TH_LO <= TH_HI && TH_HI < VHI && VLO <= VINIT && VINIT <= VHI)) begin : g_bad_levels
        $error("spice_node_integrator: rail/threshold/init ordering violated");
    end
    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("spice_node_integrator: SETTLE must be in 1..255");
    end

    typedef enum logic {LOW, HIGH} state_t;

    logic signed [SW-1:0] sum, delta;
    logic signed [SX-1:0] v_wide, f_wide;
    logic signed [W-1:0]  v_q, v_d, v_next, f_clamp;
    logic [7:0]           cnt_q, cnt_d;
    logic                 settled_q, settled_d, quiet;
    state_t               state_q, state_d;

    function automatic logic signed [W-1:0] clamp(input logic signed [SX-1:0] x);
        return W'(x > HI_X ? HI_X : x < LO_X ? LO_X : x);
    endfunction

    // The adder is wide enough that no sum of N currents plus v can wrap before clamping.
    always_comb begin
        sum = '0;
        for (int k = 0; k < N; k++) sum += SW'($signed(i_in[k*W +: W]));
        delta     = sum >>> SHIFT;
        v_wide    = SX'(v_q) + SX'(delta);
        f_wide    = SX'($signed(force_v));
        v_next    = clamp(v_wide);
        f_clamp   = clamp(f_wide);
        quiet     = v_next == v_q;
        v_d       = force_en ? f_clamp : step ? v_next : v_q;
        cnt_d     = force_en ? '0 : !step ? cnt_q : !quiet ? '0 : cnt_q == SET8 ? cnt_q : cnt_q + 8'd1;
        settled_d = force_en ? 1'b0 : step ? cnt_d == SET8 : settled_q;
        state_d   = !(force_en || step) ? state_q :
                    state_q == LOW ? (v_d > TH_HI_W ? HIGH : LOW) : (v_d < TH_LO_W ? LOW : HIGH);
    end

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            v_q       <= VINIT_W;
            cnt_q     <= '0;
            settled_q <= 1'b0;
            state_q   <= LOW;
        end else begin
            v_q       <= v_d;
            cnt_q     <= cnt_d;
            settled_q <= settled_d;
            state_q   <= state_d;
        end
    end

    assign v       = v_q;
    assign p       = state_q == HIGH;
    assign settled = settled_q;
    assign sat_hi  = v_q == VHI_W;
    assign sat_lo  = v_q == VLO_W;
endmodule

// File: tb/tb_spice_node_integrator.sv
// tb_spice_node_integrator: directed stimulus, integer reference model checked every
// cycle on two instances (SHIFT=0 and SHIFT=2), plus hand-computed expectations.
module tb_spice_node_integrator;
    localparam int VHI = 12288, VLO = -12288, TH_HI = 2048, TH_LO = -2048, SETTLE = 4;

    logic        eclk = 0, ereset_n, step, force_en;
    logic [15:0] force_v;
    logic [63:0] i_in;
    logic [15:0] v0, v2;
    logic        p0, p2, s0, s2, hi0, hi2, lo0, lo2;
    int          n_cmp = 0, n_bad = 0;

    int mv[2], mc[2];
    bit mp[2], ms[2];
    int sh[2] = '{0, 2};

    spice_node_integrator dut0 (
        .eclk(eclk), .ereset_n(ereset_n), .step(step), .force_en(force_en), .force_v(force_v),
        .i_in(i_in), .v(v0), .p(p0), .settled(s0), .sat_hi(hi0), .sat_lo(lo0)
    );
    spice_node_integrator #(.SHIFT(2)) dut2 (
        .eclk(eclk), .ereset_n(ereset_n), .step(step), .force_en(force_en), .force_v(force_v),
        .i_in(i_in), .v(v2), .p(p2), .settled(s2), .sat_hi(hi2), .sat_lo(lo2)
    );

    always #5 eclk = ~eclk;

    function automatic int clampv(int x);
        return x > VHI ? VHI : x < VLO ? VLO : x;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: node as a plain integer, digital level as a hysteresis bit.
    always @(posedge eclk or negedge ereset_n) begin
        int sum, nv;
        if (!ereset_n) begin
            for (int j = 0; j < 2; j++) begin mv[j] = 0; mc[j] = 0; mp[j] = 0; ms[j] = 0; end
        end else begin
            sum = 0;
            for (int k = 0; k < 4; k++) sum += $signed(i_in[k*16 +: 16]);
            for (int j = 0; j < 2; j++) begin
                nv = force_en ? clampv($signed(force_v)) : step ? clampv(mv[j] + (sum >>> sh[j])) : mv[j];
                if (force_en || step) begin
                    if (nv > TH_HI) mp[j] = 1;
                    else if (nv < TH_LO) mp[j] = 0;
                end
                if (force_en) begin
                    mc[j] = 0; ms[j] = 0;
                end else if (step) begin
                    mc[j] = (nv == mv[j]) ? (mc[j] < SETTLE ? mc[j] + 1 : SETTLE) : 0;
                    ms[j] = mc[j] == SETTLE;
                end
                mv[j] = nv;
            end
        end
    end

    always @(negedge eclk) if (ereset_n) begin
        chk("v0", $signed(v0), mv[0]);
        chk("p0", int'(p0), int'(mp[0]));
        chk("settled0", int'(s0), int'(ms[0]));
        chk("sat_hi0", int'(hi0), int'(mv[0] == VHI));
        chk("sat_lo0", int'(lo0), int'(mv[0] == VLO));
        chk("v2", $signed(v2), mv[1]);
        chk("p2", int'(p2), int'(mp[1]));
        chk("settled2", int'(s2), int'(ms[1]));
        chk("sat_hi2", int'(hi2), int'(mv[1] == VHI));
        chk("sat_lo2", int'(lo2), int'(mv[1] == VLO));
    end

    task automatic tick(int n);
        repeat (n) begin @(posedge eclk); @(negedge eclk); end
    endtask

    task automatic set_i(int a, int b, int c, int d);
        i_in = {16'(d), 16'(c), 16'(b), 16'(a)};
    endtask

    task automatic do_reset();
        #2 ereset_n = 0;
        #2 ereset_n = 1;
        @(negedge eclk);
    endtask

    initial begin
        ereset_n = 0; step = 0; force_en = 0; force_v = '0; set_i(0, 0, 0, 0);
        @(negedge eclk);
        chk("rst_v", $signed(v0), 0);
        chk("rst_p", int'(p0), 0);
        chk("rst_settled", int'(s0), 0);
        chk("rst_sat", int'({hi0, lo0}), 0);
        ereset_n = 1;
        // quiet steps from zero
        step = 1;
        tick(3); chk("t1_settled_3", int'(s0), 0);
        tick(1); chk("t1_settled_4", int'(s0), 1); chk("t1_v", $signed(v0), 0);
        // ramp +100 per step
        step = 0; do_reset(); set_i(100, 0, 0, 0); step = 1;
        tick(20); chk("t2_v20", $signed(v0), 2000); chk("t2_p20", int'(p0), 0);
        tick(1); chk("t2_v21", $signed(v0), 2100); chk("t2_p21", int'(p0), 1); chk("t2_settled", int'(s0), 0);
        // wide sum into the upper rail
        step = 0; do_reset(); set_i(32767, 32767, 32767, 32767); step = 1;
        tick(1); chk("t3_v", $signed(v0), 12288); chk("t3_sat_hi", int'(hi0), 1);
        tick(3); chk("t3_settled_3", int'(s0), 0);
        tick(1); chk("t3_settled_4", int'(s0), 1);
        set_i(-100, 0, 0, 0);
        tick(1); chk("t3_v_down", $signed(v0), 12188); chk("t3_unsettle", int'(s0), 0);
        // hysteresis on the way down
        step = 0; force_en = 1; force_v = 16'(12288); tick(1); force_en = 0;
        chk("t4_p_start", int'(p0), 1);
        set_i(-1000, 0, 0, 0); step = 1;
        tick(14); chk("t4_v14", $signed(v0), -1712); chk("t4_p14", int'(p0), 1);
        tick(1); chk("t4_v15", $signed(v0), -2712); chk("t4_p15", int'(p0), 0);
        // SHIFT=2 floors -1/4 to -1
        step = 0; do_reset(); set_i(-1, 0, 0, 0); step = 1;
        tick(1); chk("t4s_v1", $signed(v2), -1);
        tick(2); chk("t4s_v3", $signed(v2), -3);
        // async reset while settled and high
        step = 0; force_en = 1; force_v = 16'(5000); tick(1); force_en = 0;
        set_i(0, 0, 0, 0); step = 1;
        tick(4); chk("t6_pre_v", $signed(v0), 5000); chk("t6_pre_p", int'(p0), 1); chk("t6_pre_s", int'(s0), 1);
        #2 ereset_n = 0;
        #1 chk("t6_async_v", $signed(v0), 0); chk("t6_async_p", int'(p0), 0); chk("t6_async_s", int'(s0), 0);
        #1 ereset_n = 1; set_i(100, 0, 0, 0);
        @(negedge eclk); chk("t6_resume", $signed(v0), 100);
        // force beats step and clamps to the lower rail
        step = 0; force_en = 1; force_v = 16'(5000); tick(1);
        chk("t5_pre_p", int'(p0), 1);
        force_v = 16'(-20000); step = 1; tick(1);
        chk("t5_v", $signed(v0), -12288); chk("t5_sat_lo", int'(lo0), 1);
        chk("t5_p", int'(p0), 0); chk("t5_settled", int'(s0), 0);
        force_en = 0; set_i(0, 0, 0, 0);
        tick(3); chk("t5_cnt_cleared", int'(s0), 0);
        tick(1); chk("t5_settled_4", int'(s0), 1);
        step = 0; tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
